// File: rtl/key_event_decoder_pkg.sv
// Shared types for the washer key path: FSM state encoding, downstream event
// codes and small elaboration helpers.
package washer_key_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PRESS1   = 3'd1;
  localparam logic [2:0] ST_GAP      = 3'd2;
  localparam logic [2:0] ST_WAIT_REL = 3'd3;
  localparam logic [2:0] ST_HOLD     = 3'd4;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    PRESS1   = ST_PRESS1,
    GAP      = ST_GAP,
    WAIT_REL = ST_WAIT_REL,
    HOLD     = ST_HOLD
  } key_state_e;

  typedef enum logic [2:0] {
    EV_NONE   = 3'd0,
    EV_SHORT  = 3'd1,
    EV_DOUBLE = 3'd2,
    EV_LONG   = 3'd3,
    EV_REPEAT = 3'd4
  } key_event_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Collapses the one-hot pulse outputs into a single code for consumers.
  function automatic key_event_e event_code(input logic s, input logic d,
                                            input logic l, input logic r);
    key_event_e e;
    if (s) begin
      e = EV_SHORT;
    end else if (d) begin
      e = EV_DOUBLE;
    end else if (l) begin
      e = EV_LONG;
    end else if (r) begin
      e = EV_REPEAT;
    end else begin
      e = EV_NONE;
    end
    return e;
  endfunction

endpackage

// File: rtl/key_event_decoder_ms_tick_gen.sv
// Millisecond prescaler: counts 0..TICK_CYCLES-1 and flags the wrap cycle.
// clr restarts the interval so callers can time exactly from an event.
module ms_tick_gen #(
  parameter int TICK_CYCLES = 50_000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic clr,
  output logic tick
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] TOP = PW'(TICK_CYCLES - 1);

  logic [PW-1:0] r_presc;

  assign tick = (r_presc == TOP);

  // Prescaler counter, restarted on wrap or on request.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_presc <= {PW{1'b0}};
    end else if (clr || tick) begin
      r_presc <= {PW{1'b0}};
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

endmodule

// File: rtl/key_event_decoder.sv
// Classifies debounced (active-low) key gestures into single-cycle event
// pulses: short click, double click, long press and auto-repeat.
module key_event_decoder
  import washer_key_pkg::*;
#(
  parameter int TICK_CYCLES = 50_000,
  parameter int LONG_MS     = 1000,
  parameter int DBL_MS      = 300,
  parameter int REPEAT_MS   = 200
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic key_press,
  output logic short_click,
  output logic double_click,
  output logic long_press,
  output logic long_repeat,
  output logic key_held
);

  localparam int MAX_MS = max3(LONG_MS, DBL_MS, REPEAT_MS);
  localparam int CNT_W  = $clog2(MAX_MS + 1);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_MS - 1);
  localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_MS - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_MS - 1);

  key_state_e       r_state;
  logic             r_key_prev;
  logic [CNT_W-1:0] r_ms_cnt;
  logic             r_short;
  logic             r_double;
  logic             r_long;
  logic             r_repeat;
  logic             r_held;

  logic w_tick;
  logic w_clr;
  logic w_press_edge;
  logic w_release_edge;
  logic w_long_hit;
  logic w_dbl_hit;
  logic w_rep_hit;
  logic w_timed;

  assign w_press_edge   = r_key_prev & ~key_press;
  assign w_release_edge = ~r_key_prev & key_press;
  assign w_long_hit     = w_tick && (r_ms_cnt == LONG_LAST);
  assign w_dbl_hit      = w_tick && (r_ms_cnt == DBL_LAST);
  assign w_rep_hit      = w_tick && (r_ms_cnt == REP_LAST);
  assign w_timed        = (r_state == PRESS1) || (r_state == GAP) || (r_state == HOLD);

  ms_tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick (
    .CLK  (CLK),
    .RST_N(RST_N),
    .clr  (w_clr),
    .tick (w_tick)
  );

  // Interval restart: any transition (and each repeat) re-times from this cycle.
  always_comb begin
    w_clr = 1'b0;
    case (r_state)
      IDLE:     w_clr = w_press_edge;
      PRESS1:   w_clr = w_release_edge | w_long_hit;
      GAP:      w_clr = w_press_edge | w_dbl_hit;
      WAIT_REL: w_clr = w_release_edge;
      HOLD:     w_clr = w_release_edge | w_rep_hit;
      default:  w_clr = 1'b1;
    endcase
  end

  // Millisecond counter for the timed states.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ms_cnt <= {CNT_W{1'b0}};
    end else if (w_clr) begin
      r_ms_cnt <= {CNT_W{1'b0}};
    end else if (w_tick && w_timed) begin
      r_ms_cnt <= r_ms_cnt + CNT_W'(1);
    end else begin
      r_ms_cnt <= r_ms_cnt;
    end
  end

  // Gesture FSM with registered pulses; edges are checked before timeouts.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= IDLE;
      r_key_prev <= 1'b0;
      r_short    <= 1'b0;
      r_double   <= 1'b0;
      r_long     <= 1'b0;
      r_repeat   <= 1'b0;
      r_held     <= 1'b0;
    end else begin
      r_key_prev <= key_press;
      r_short    <= 1'b0;
      r_double   <= 1'b0;
      r_long     <= 1'b0;
      r_repeat   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_press_edge) begin
            r_state <= PRESS1;
            r_held  <= 1'b1;
          end else begin
            r_held  <= 1'b0;
          end
        end
        PRESS1: begin
          if (w_release_edge) begin
            r_state <= GAP;
            r_held  <= 1'b0;
          end else if (w_long_hit) begin
            r_state <= HOLD;
            r_long  <= 1'b1;
            r_held  <= 1'b1;
          end else begin
            r_held  <= 1'b1;
          end
        end
        GAP: begin
          if (w_press_edge) begin
            r_state  <= WAIT_REL;
            r_double <= 1'b1;
            r_held   <= 1'b1;
          end else if (w_dbl_hit) begin
            r_state  <= IDLE;
            r_short  <= 1'b1;
            r_held   <= 1'b0;
          end else begin
            r_held   <= 1'b0;
          end
        end
        WAIT_REL: begin
          if (w_release_edge) begin
            r_state <= IDLE;
            r_held  <= 1'b0;
          end else begin
            r_held  <= 1'b1;
          end
        end
        HOLD: begin
          if (w_release_edge) begin
            r_state  <= IDLE;
            r_held   <= 1'b0;
          end else if (w_rep_hit) begin
            r_repeat <= 1'b1;
            r_held   <= 1'b1;
          end else begin
            r_held   <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_held  <= 1'b0;
        end
      endcase
    end
  end

  assign short_click  = r_short;
  assign double_click = r_double;
  assign long_press   = r_long;
  assign long_repeat  = r_repeat;
  assign key_held     = r_held;

endmodule
